// File: rtl/ov7670_mem_writer_if.sv
// Camera-side inputs and frame-buffer write-side outputs of the OV7670 capture stage.
interface ov7670_mem_writer_if #(
    parameter int unsigned ADDR_W = 17
);
    logic              vsync;
    logic              href;
    logic [7:0]        data;
    logic              we;
    logic [ADDR_W-1:0] wAddr;
    logic [15:0]       wData;
    logic              frame_done;
    logic              line_err;

    // Driver side: camera stimulus out, frame-buffer writes in
    modport master (
        output vsync, href, data,
        input  we, wAddr, wData, frame_done, line_err
    );

    // Capture block side
    modport slave (
        input  vsync, href, data,
        output we, wAddr, wData, frame_done, line_err
    );
endinterface

// File: rtl/ov7670_mem_writer.sv
// OV7670 capture stage: pairs camera bytes into RGB565 pixels and writes whole frames
// into an H_SIZE x V_SIZE frame buffer. Everything runs on PCLK.
module ov7670_mem_writer #(
    parameter int unsigned H_SIZE = 320,
    parameter int unsigned V_SIZE = 240,
    parameter int unsigned ADDR_W = $clog2(H_SIZE * V_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ov7670_mem_writer_if.slave   bus
);
    localparam logic [1:0] S_WAIT_VS = 2'd0;
    localparam logic [1:0] S_BLANK   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    localparam logic [9:0] CntMax = 10'h3FF;
    localparam logic [9:0] HLim   = 10'(H_SIZE);
    localparam logic [9:0] VLim   = 10'(V_SIZE);

    logic [1:0]        state_q, state_d;
    logic [9:0]        col_q, col_d;
    logic [9:0]        row_q, row_d;
    // row_q * H_SIZE, kept incrementally so no multiplier is needed
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              phase_q, phase_d;
    logic              href_q, href_d;
    logic [7:0]        byte0_q, byte0_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              frame_done_q, frame_done_d;
    logic              line_err_q, line_err_d;

    // Next-state: frame FSM, byte pairing, line/row counting and write generation
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        row_base_d   = row_base_q;
        phase_d      = phase_q;
        href_d       = href_q;
        byte0_d      = byte0_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        frame_done_d = 1'b0;
        line_err_d   = 1'b0;

        case (state_q)
            S_WAIT_VS: begin
                if (bus.vsync) state_d = S_BLANK;
            end
            S_BLANK: begin
                if (!bus.vsync) begin
                    state_d    = S_CAPTURE;
                    col_d      = '0;
                    row_d      = '0;
                    row_base_d = '0;
                    phase_d    = 1'b0;
                    href_d     = 1'b0;
                end
            end
            S_CAPTURE: begin
                if (bus.vsync) begin
                    // Frame ends at once; any half pixel is dropped
                    state_d      = S_BLANK;
                    frame_done_d = 1'b1;
                    phase_d      = 1'b0;
                    href_d       = 1'b0;
                end else begin
                    href_d = bus.href;
                    if (bus.href) begin
                        if (!phase_q) begin
                            byte0_d = bus.data;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (col_q < HLim && row_q < VLim) begin
                                we_d    = 1'b1;
                                waddr_d = row_base_q + ADDR_W'(col_q);
                                wdata_d = {byte0_q, bus.data};
                            end
                            if (col_q != CntMax) col_d = col_q + 10'd1;
                        end
                    end else if (href_q) begin
                        // Line end: odd trailing byte discarded
                        phase_d = 1'b0;
                        if (col_q != '0) begin
                            col_d      = '0;
                            line_err_d = (col_q != HLim);
                            if (row_q != CntMax) row_d = row_q + 10'd1;
                            // Base only matters while the next row is still inside the frame
                            if (row_q + 10'd1 < VLim) row_base_d = row_base_q + ADDR_W'(H_SIZE);
                        end
                    end
                end
            end
            default: state_d = S_WAIT_VS;
        endcase
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_WAIT_VS;
            col_q        <= '0;
            row_q        <= '0;
            row_base_q   <= '0;
            phase_q      <= 1'b0;
            href_q       <= 1'b0;
            byte0_q      <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            row_base_q   <= row_base_d;
            phase_q      <= phase_d;
            href_q       <= href_d;
            byte0_q      <= byte0_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
        end
    end

    assign bus.we         = we_q;
    assign bus.wAddr      = waddr_q;
    assign bus.wData      = wdata_q;
    assign bus.frame_done = frame_done_q;
    assign bus.line_err   = line_err_q;
endmodule

// File: tb/tb_ov7670_mem_writer.sv
// Bench for ov7670_mem_writer: line-level reference model with a write scoreboard,
// a table of line shapes, and hand sequences for timing, reset and frame-edge cases.
module tb_ov7670_mem_writer;
    localparam int unsigned H  = 320;
    localparam int unsigned V  = 8;
    localparam int unsigned AW = $clog2(H * V);

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;
    typedef struct {
        int nbytes;
        int exp_wr;
        int exp_le;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    ov7670_mem_writer_if #(.ADDR_W(AW)) bus_if ();

    ov7670_mem_writer #(.H_SIZE(H), .V_SIZE(V), .ADDR_W(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  failures = 0;
    wr_t exp_q[$];
    wr_t mon_e;
    int  wr_count = 0;
    int  fd_count = 0;
    int  le_count = 0;
    int  exp_fd = 0;
    int  exp_le = 0;
    bit  cap = 1'b0;
    int  mrow = 0;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endfunction

    // Write monitor / scoreboard plus pulse counters, sampled 1 time unit after the edge
    always @(posedge clk) begin
        #1;
        if (reset_n === 1'b1 && bus_if.we === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%0h data=%0h required=no_write",
                         bus_if.wAddr, bus_if.wData);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(bus_if.wAddr), 32'(mon_e.addr));
                chk("wr_data", 32'(bus_if.wData), 32'(mon_e.data));
            end
        end
        if (bus_if.frame_done === 1'b1) fd_count++;
        if (bus_if.line_err === 1'b1) le_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bq_t rand_bytes(int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Counting pattern: each pixel's value is its own frame index
    function automatic bq_t count_bytes(int row);
        bq_t q;
        logic [15:0] v;
        for (int c = 0; c < int'(H); c++) begin
            v = 16'(row * int'(H) + c);
            q.push_back(v[15:8]);
            q.push_back(v[7:0]);
        end
        return q;
    endfunction

    // Reference: expected writes and line error for one line of camera bytes
    task automatic model_line(input bq_t b, input bit line_end);
        int p;
        wr_t w;
        p = b.size() / 2;
        if (!cap) return;
        for (int c = 0; c < p; c++) begin
            if (c < int'(H) && mrow < int'(V)) begin
                w.addr = AW'(mrow * int'(H) + c);
                w.data = {b[2*c], b[2*c+1]};
                exp_q.push_back(w);
            end
        end
        if (line_end && p > 0) begin
            if (p != int'(H)) exp_le++;
            mrow++;
        end
    endtask

    task automatic drive_line(input bq_t b);
        for (int i = 0; i < b.size(); i++) begin
            bus_if.href = 1'b1;
            bus_if.data = b[i];
            tick();
        end
        bus_if.href = 1'b0;
        bus_if.data = 8'($urandom);
        repeat (4) tick();
    endtask

    task automatic line(input bq_t b);
        model_line(b, 1'b1);
        drive_line(b);
    endtask

    task automatic vsync_pulse();
        bus_if.vsync = 1'b1;
        if (cap) exp_fd++;
        cap = 1'b0;
        repeat (3) tick();
        bus_if.vsync = 1'b0;
        cap  = 1'b1;
        mrow = 0;
        repeat (3) tick();
    endtask

    task automatic checkpoint(string tag);
        repeat (2) tick();
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_frame_done"}, 32'(fd_count), 32'(exp_fd));
        chk({tag, "_line_err"}, 32'(le_count), 32'(exp_le));
    endtask

    vec_t tbl[7];
    bq_t  b;
    int   w0;
    int   l0;
    int   f0;

    initial begin
        tbl[0] = '{nbytes: 640, exp_wr: 320, exp_le: 0};
        tbl[1] = '{nbytes: 644, exp_wr: 320, exp_le: 1};
        tbl[2] = '{nbytes: 638, exp_wr: 319, exp_le: 1};
        tbl[3] = '{nbytes: 639, exp_wr: 319, exp_le: 1};
        tbl[4] = '{nbytes: 641, exp_wr: 320, exp_le: 0};
        tbl[5] = '{nbytes: 2,   exp_wr: 1,   exp_le: 1};
        tbl[6] = '{nbytes: 1,   exp_wr: 0,   exp_le: 0};

        // Reset state
        reset_n = 1'b0;
        bus_if.vsync = 1'b0;
        bus_if.href  = 1'b0;
        bus_if.data  = 8'h00;
        repeat (3) tick();
        chk("rst_we", 32'(bus_if.we), 32'd0);
        chk("rst_waddr", 32'(bus_if.wAddr), 32'd0);
        chk("rst_wdata", 32'(bus_if.wData), 32'd0);
        chk("rst_frame_done", 32'(bus_if.frame_done), 32'd0);
        chk("rst_line_err", 32'(bus_if.line_err), 32'd0);
        reset_n = 1'b1;
        tick();

        // Bytes before any vsync pulse must not be written
        line(rand_bytes(40));
        line(rand_bytes(17));
        chk("precap_writes", 32'(wr_count), 32'd0);

        // Two-pixel line with exact write timing
        vsync_pulse();
        b = '{8'hF8, 8'h00, 8'h07, 8'hE0};
        model_line(b, 1'b1);
        bus_if.href = 1'b1;
        bus_if.data = 8'hF8; tick();
        chk("px_we_b0", 32'(bus_if.we), 32'd0);
        bus_if.data = 8'h00; tick();
        chk("px_we_b1", 32'(bus_if.we), 32'd1);
        chk("px_addr0", 32'(bus_if.wAddr), 32'd0);
        chk("px_data0", 32'(bus_if.wData), 32'hF800);
        bus_if.data = 8'h07; tick();
        chk("px_we_b2", 32'(bus_if.we), 32'd0);
        chk("px_addr_hold", 32'(bus_if.wAddr), 32'd0);
        bus_if.data = 8'hE0; tick();
        chk("px_we_b3", 32'(bus_if.we), 32'd1);
        chk("px_addr1", 32'(bus_if.wAddr), 32'd1);
        chk("px_data1", 32'(bus_if.wData), 32'h07E0);
        bus_if.href = 1'b0; tick();
        chk("px_we_end", 32'(bus_if.we), 32'd0);
        chk("px_line_err", 32'(bus_if.line_err), 32'd1);
        repeat (3) tick();
        vsync_pulse();
        checkpoint("px");

        // Table of line shapes within one frame
        for (int i = 0; i < 7; i++) begin
            w0 = wr_count;
            l0 = le_count;
            line(rand_bytes(tbl[i].nbytes));
            chk($sformatf("tbl%0d_writes", i), 32'(wr_count - w0), 32'(tbl[i].exp_wr));
            chk($sformatf("tbl%0d_line_err", i), 32'(le_count - l0), 32'(tbl[i].exp_le));
        end
        vsync_pulse();
        checkpoint("tbl");

        // Full frame, counting pattern
        w0 = wr_count;
        for (int r = 0; r < int'(V); r++) line(count_bytes(r));
        f0 = fd_count;
        vsync_pulse();
        checkpoint("full");
        chk("full_writes", 32'(wr_count - w0), 32'(H * V));
        chk("full_fd_once", 32'(fd_count - f0), 32'd1);

        // Oversize frame: rows past V_SIZE write nothing
        w0 = wr_count;
        for (int r = 0; r < int'(V) + 2; r++) line(rand_bytes(2 * H));
        f0 = fd_count;
        vsync_pulse();
        checkpoint("over");
        chk("over_writes", 32'(wr_count - w0), 32'(H * V));
        chk("over_fd", 32'(fd_count - f0), 32'd1);

        // Reset mid-frame
        for (int r = 0; r < 4; r++) line(rand_bytes(2 * H));
        reset_n = 1'b0;
        tick();
        chk("mid_rst_we", 32'(bus_if.we), 32'd0);
        chk("mid_rst_waddr", 32'(bus_if.wAddr), 32'd0);
        chk("mid_rst_wdata", 32'(bus_if.wData), 32'd0);
        chk("mid_rst_frame_done", 32'(bus_if.frame_done), 32'd0);
        chk("mid_rst_line_err", 32'(bus_if.line_err), 32'd0);
        reset_n = 1'b1;
        cap = 1'b0;
        w0 = wr_count;
        for (int r = 4; r < int'(V); r++) line(rand_bytes(2 * H));
        chk("after_rst_writes", 32'(wr_count - w0), 32'd0);
        vsync_pulse();
        line(rand_bytes(2 * H));
        checkpoint("rst");

        // vsync rises while href is high with an odd byte pending
        b = rand_bytes(21);
        model_line(b, 1'b0);
        for (int i = 0; i < b.size(); i++) begin
            bus_if.href = 1'b1;
            bus_if.data = b[i];
            tick();
        end
        bus_if.vsync = 1'b1;
        exp_fd++;
        cap = 1'b0;
        repeat (2) tick();
        bus_if.href = 1'b0;
        tick();
        bus_if.vsync = 1'b0;
        cap  = 1'b1;
        mrow = 0;
        repeat (3) tick();
        line(rand_bytes(10));
        vsync_pulse();
        checkpoint("cut");

        // Randomised frames
        for (int f = 0; f < 2; f++) begin
            int nl;
            nl = int'(V) + int'($urandom_range(0, 2));
            for (int l = 0; l < nl; l++) begin
                int sel;
                int np;
                sel = int'($urandom_range(0, 5));
                if (sel <= 2) np = int'(H);
                else if (sel == 3) np = int'($urandom_range(H - 2, H + 2));
                else np = int'($urandom_range(0, 5));
                line(rand_bytes(2 * np + int'($urandom_range(0, 1))));
            end
            vsync_pulse();
            checkpoint($sformatf("rand%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
